// File: rtl/phv_pkt_deparser_if.sv
// Bus bundle for phv_pkt_deparser: packet input stream, PHV strobe,
// registered valid/ready output stream, error flag and statistics.
// master = stimulus/consumer side, slave = deparser side.
interface phv_pkt_deparser_if #(
    parameter int PHV_WIDTH = 1024
);
    logic                 i_pkt_valid;
    logic [133:0]         i_pkt;
    logic                 i_phv_valid;
    logic [PHV_WIDTH-1:0] i_phv;
    logic                 o_pkt_valid;
    logic [133:0]         o_pkt;
    logic                 i_ready;
    logic                 o_err_ovf;
    logic [31:0]          o_cnt_tx;
    logic [31:0]          o_cnt_drop;

    modport master (
        output i_pkt_valid, i_pkt, i_phv_valid, i_phv, i_ready,
        input  o_pkt_valid, o_pkt, o_err_ovf, o_cnt_tx, o_cnt_drop
    );

    modport slave (
        input  i_pkt_valid, i_pkt, i_phv_valid, i_phv, i_ready,
        output o_pkt_valid, o_pkt, o_err_ovf, o_cnt_tx, o_cnt_drop
    );
endinterface

// File: rtl/phv_pkt_deparser.sv
// phv_pkt_deparser: buffers the original 134b packet stream and re-emits each
// packet once its processed PHV arrives, overwriting the first PKT_NUM beats'
// data with PHV slices (most significant slice first).
// Optional feature macro: DEPARSER_CNT_EN enables the o_cnt_tx / o_cnt_drop
// packet counters; when undefined both outputs are tied to zero.
module phv_pkt_deparser #(
    parameter int PHV_WIDTH      = 1024,
    parameter int PKT_NUM        = PHV_WIDTH / 128 - 1,
    parameter int PKT_FIFO_DEPTH = 256,
    parameter int MAX_PKT_BEATS  = 96,
    parameter int DESC_DEPTH     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    phv_pkt_deparser_if.slave  bus
);
    localparam int PF_AW = $clog2(PKT_FIFO_DEPTH);
    localparam int DF_AW = $clog2(DESC_DEPTH);
    localparam int KW    = $clog2(PKT_NUM + 1);

    typedef logic [PF_AW:0] pf_ptr_t;
    typedef logic [DF_AW:0] df_ptr_t;
    typedef logic [KW-1:0]  k_t;
    typedef enum logic { S_IDLE = 1'b0, S_SEND = 1'b1 } state_t;

    localparam pf_ptr_t    PF_DEPTH_V  = pf_ptr_t'(PKT_FIFO_DEPTH);
    localparam pf_ptr_t    MAX_BEATS_V = pf_ptr_t'(MAX_PKT_BEATS);
    localparam df_ptr_t    DF_DEPTH_V  = df_ptr_t'(DESC_DEPTH);
    localparam k_t         K_MAX       = k_t'(PKT_NUM);
    localparam logic [1:0] TAG_HEAD    = 2'b01;
    localparam logic [1:0] TAG_TAIL    = 2'b10;

    // Storage: packet buffer, per-packet drop descriptors, pending PHVs
    logic [133:0]         pf_mem [PKT_FIFO_DEPTH];
    logic                 df_mem [DESC_DEPTH];
    logic [PHV_WIDTH-1:0] hf_mem [DESC_DEPTH];

    pf_ptr_t pf_wr_q, pf_rd_q;
    df_ptr_t df_wr_q, df_rd_q, hf_wr_q, hf_rd_q;
    logic    in_acc_q, in_acc_d;
    state_t  state_q, state_d;
    k_t      k_q, k_d, k_eff;
    logic [PHV_WIDTH-1:0] hold_q, cur_phv;
    logic [133:0] o_pkt_q, o_pkt_d, pf_beat, out_beat;
    logic    o_vld_q, o_vld_d, err_q;

    // Selects 128b slice k counted from the PHV's most significant end
    function automatic logic [127:0] phv_slice(input logic [PHV_WIDTH-1:0] v, input k_t k);
        logic [PHV_WIDTH-1:0] sh;
        sh = v << (128 * k);
        return sh[PHV_WIDTH-1 -: 128];
    endfunction

    pf_ptr_t pf_cnt;
    df_ptr_t df_cnt, hf_cnt;
    logic pf_empty, pf_room, df_full, df_empty, hf_full, hf_empty;
    logic is_head, is_tail, admit, pf_push, df_push, hf_push, ovf;
    logic pair_rdy, head_drop, start, active, out_free, take, take_tail, pop_pair;

    assign pf_cnt   = pf_wr_q - pf_rd_q;
    assign df_cnt   = df_wr_q - df_rd_q;
    assign hf_cnt   = hf_wr_q - hf_rd_q;
    assign pf_empty = (pf_cnt == '0);
    assign pf_room  = ((PF_DEPTH_V - pf_cnt) >= MAX_BEATS_V);
    assign df_full  = (df_cnt == DF_DEPTH_V);
    assign df_empty = (df_cnt == '0);
    assign hf_full  = (hf_cnt == DF_DEPTH_V);
    assign hf_empty = (hf_cnt == '0);

    // Admission: decision taken at the head beat, remembered through the tail
    assign is_head = bus.i_pkt_valid && (bus.i_pkt[133:132] == TAG_HEAD);
    assign is_tail = bus.i_pkt_valid && (bus.i_pkt[133:132] == TAG_TAIL);
    assign admit   = pf_room && !df_full;
    assign pf_push = bus.i_pkt_valid && (is_head ? admit : in_acc_q);
    assign df_push = is_head && !df_full;
    assign hf_push = bus.i_phv_valid && !hf_full;
    assign ovf     = (is_head && df_full) || (bus.i_phv_valid && hf_full);

    // Emission: in IDLE the FIFO-head PHV is used directly so the first beat
    // can be issued in the same cycle the descriptor/PHV pair is popped.
    assign pair_rdy  = !df_empty && !hf_empty;
    assign head_drop = df_mem[df_rd_q[DF_AW-1:0]];
    assign start     = (state_q == S_IDLE) && pair_rdy && !head_drop;
    assign pop_pair  = (state_q == S_IDLE) && pair_rdy;
    assign active    = start || (state_q == S_SEND);
    assign out_free  = !o_vld_q || bus.i_ready;
    assign pf_beat   = pf_mem[pf_rd_q[PF_AW-1:0]];
    assign take      = active && !pf_empty && out_free;
    assign take_tail = take && (pf_beat[133:132] == TAG_TAIL);

    // Admission flag tracks whether the current packet's beats are stored
    always_comb begin
        in_acc_d = in_acc_q;
        if (is_head)      in_acc_d = admit;
        else if (is_tail) in_acc_d = 1'b0;
    end

    // FSM state register and control registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            in_acc_q <= 1'b0;
            pf_wr_q  <= '0;
            pf_rd_q  <= '0;
            df_wr_q  <= '0;
            df_rd_q  <= '0;
            hf_wr_q  <= '0;
            hf_rd_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            in_acc_q <= in_acc_d;
            if (pf_push)  pf_wr_q <= pf_wr_q + pf_ptr_t'(1);
            if (take)     pf_rd_q <= pf_rd_q + pf_ptr_t'(1);
            if (df_push)  df_wr_q <= df_wr_q + df_ptr_t'(1);
            if (hf_push)  hf_wr_q <= hf_wr_q + df_ptr_t'(1);
            if (pop_pair) begin
                df_rd_q <= df_rd_q + df_ptr_t'(1);
                hf_rd_q <= hf_rd_q + df_ptr_t'(1);
            end
            if (ovf)      err_q <= 1'b1;
        end
    end

    // FSM next-state: leave IDLE on a kept packet, return after its tail
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !take_tail) state_d = S_SEND;
            S_SEND:  if (take_tail)           state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: beat index, beat composition and output-stage next value
    always_comb begin
        k_eff   = (state_q == S_IDLE) ? '0 : k_q;
        cur_phv = (state_q == S_IDLE) ? hf_mem[hf_rd_q[DF_AW-1:0]] : hold_q;
        k_d     = k_eff;
        if (take) k_d = (k_eff == K_MAX) ? K_MAX : k_eff + k_t'(1);
        out_beat = pf_beat;
        if (k_eff < K_MAX) out_beat[127:0] = phv_slice(cur_phv, k_eff);
        o_pkt_d = o_pkt_q;
        o_vld_d = o_vld_q;
        if (take) begin
            o_pkt_d = out_beat;
            o_vld_d = 1'b1;
        end else if (bus.i_ready) begin
            o_vld_d = 1'b0;
        end
    end

    // Registered output stage, held while downstream is not ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pkt_q <= '0;
            o_vld_q <= 1'b0;
        end else begin
            o_pkt_q <= o_pkt_d;
            o_vld_q <= o_vld_d;
        end
    end

    // Storage writes and PHV hold register (data only, no reset)
    always_ff @(posedge i_clk) begin
        if (pf_push) pf_mem[pf_wr_q[PF_AW-1:0]] <= bus.i_pkt;
        if (df_push) df_mem[df_wr_q[DF_AW-1:0]] <= ~admit;
        if (hf_push) hf_mem[hf_wr_q[DF_AW-1:0]] <= bus.i_phv;
        if (start)   hold_q <= hf_mem[hf_rd_q[DF_AW-1:0]];
    end

`ifdef DEPARSER_CNT_EN
    logic [31:0] cnt_tx_q, cnt_drop_q;

    // Packet statistics: transferred tails and admission drops, free-running
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_tx_q   <= '0;
            cnt_drop_q <= '0;
        end else begin
            if (o_vld_q && bus.i_ready && (o_pkt_q[133:132] == TAG_TAIL))
                cnt_tx_q <= cnt_tx_q + 32'd1;
            if (is_head && !admit)
                cnt_drop_q <= cnt_drop_q + 32'd1;
        end
    end

    assign bus.o_cnt_tx   = cnt_tx_q;
    assign bus.o_cnt_drop = cnt_drop_q;
`else
    assign bus.o_cnt_tx   = 32'd0;
    assign bus.o_cnt_drop = 32'd0;
`endif

    assign bus.o_pkt_valid = o_vld_q;
    assign bus.o_pkt       = o_pkt_q;
    assign bus.o_err_ovf   = err_q;
endmodule

// File: tb/tb_phv_pkt_deparser.sv
// Testbench for phv_pkt_deparser: randomized packets/PHVs checked against a
// packet-level reference model (admission rule, in-order PHV pairing, slice
// substitution on the first seven beats).
module tb_phv_pkt_deparser;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    phv_pkt_deparser_if #(.PHV_WIDTH(1024)) bus ();

    phv_pkt_deparser #(
        .PHV_WIDTH(1024), .PKT_NUM(7), .PKT_FIFO_DEPTH(256),
        .MAX_PKT_BEATS(96), .DESC_DEPTH(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus)
    );

    int n_run = 0;
    int n_fail = 0;

    logic [133:0]  rx_q[$];
    int            rx_t[$];
    int            rx_total = 0;
    int            cyc = 0;
    logic [133:0]  mbeats[$];
    int            mstart[$];
    int            mlen[$];
    int            mdesc_pid[$];
    logic [1023:0] mphv[$];
    int            exp_pid[$];
    logic [1023:0] exp_phv[$];
    logic [133:0]  exp_q[$];
    int            acc_beats = 0;
    int            exp_tx = 0;
    int            exp_drop = 0;
    bit            exp_err = 0;
    bit            rand_ready = 0;

    // Output monitor: records every transferred beat
    always @(negedge i_clk) begin
        cyc++;
        if (i_rst_n && bus.o_pkt_valid && bus.i_ready) begin
            rx_q.push_back(bus.o_pkt);
            rx_t.push_back(cyc);
            rx_total++;
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_ready) bus.i_ready = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cnt_exp(input int v);
`ifdef DEPARSER_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic [1023:0] rand_phv();
        logic [1023:0] p;
        for (int j = 0; j < 32; j++) p[j*32 +: 32] = $urandom();
        return p;
    endfunction

    function automatic logic [133:0] exp_beat(input logic [133:0] b, input logic [1023:0] p, input int k);
        logic [133:0] r;
        r = b;
        if (k < 7) r[127:0] = p[1023 - 128*k -: 128];
        return r;
    endfunction

    // Head admission: returns packet id, -1 dropped with descriptor, -2 no descriptor
    function automatic int model_head(input int nb);
        int occ;
        occ = acc_beats - rx_total;
        if (mdesc_pid.size() >= 16) begin
            exp_err = 1;
            exp_drop++;
            return -2;
        end
        if (256 - occ < 96) begin
            exp_drop++;
            mdesc_pid.push_back(-1);
            return -1;
        end
        mstart.push_back(mbeats.size());
        mlen.push_back(nb);
        mdesc_pid.push_back(mstart.size() - 1);
        return mstart.size() - 1;
    endfunction

    function automatic void model_phv(input logic [1023:0] p);
        int pid;
        logic [1023:0] v;
        if (mphv.size() >= 16) begin
            exp_err = 1;
            return;
        end
        mphv.push_back(p);
        while (mdesc_pid.size() > 0 && mphv.size() > 0) begin
            pid = mdesc_pid.pop_front();
            v = mphv.pop_front();
            if (pid >= 0) begin
                exp_pid.push_back(pid);
                exp_phv.push_back(v);
                exp_tx++;
            end
        end
    endfunction

    function automatic void expand();
        for (int i = 0; i < exp_pid.size(); i++)
            for (int k = 0; k < mlen[exp_pid[i]]; k++)
                exp_q.push_back(exp_beat(mbeats[mstart[exp_pid[i]] + k], exp_phv[i], k));
        exp_pid.delete();
        exp_phv.delete();
    endfunction

    function automatic void model_reset();
        rx_q.delete(); rx_t.delete(); mbeats.delete(); mstart.delete(); mlen.delete();
        mdesc_pid.delete(); mphv.delete(); exp_pid.delete(); exp_phv.delete(); exp_q.delete();
        rx_total = 0; acc_beats = 0; exp_tx = 0; exp_drop = 0; exp_err = 0;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // phv_at: -1 none, 0..nb-1 alongside that beat, >= nb one cycle after tail
    task automatic send_pkt(input int nb, input int gap, input int phv_at, input logic [1023:0] p);
        int pid;
        logic [1:0] tag;
        logic [133:0] b;
        pid = -1;
        for (int i = 0; i < nb; i++) begin
            tag = (i == 0) ? 2'b01 : ((i == nb - 1) ? 2'b10 : 2'b11);
            b = {tag, 4'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
            if (i == 0) pid = model_head(nb);
            if (pid >= 0) begin
                mbeats.push_back(b);
                acc_beats++;
            end
            bus.i_pkt_valid = 1'b1;
            bus.i_pkt = b;
            if (i == phv_at) begin
                bus.i_phv_valid = 1'b1;
                bus.i_phv = p;
                model_phv(p);
            end
            tick();
            bus.i_pkt_valid = 1'b0;
            bus.i_phv_valid = 1'b0;
            repeat (gap) tick();
        end
        if (phv_at >= nb) begin
            bus.i_phv_valid = 1'b1;
            bus.i_phv = p;
            model_phv(p);
            tick();
            bus.i_phv_valid = 1'b0;
        end
    endtask

    task automatic send_phv(input logic [1023:0] p);
        bus.i_phv_valid = 1'b1;
        bus.i_phv = p;
        model_phv(p);
        tick();
        bus.i_phv_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge i_clk);
            c++;
        end
        ok = (rx_q.size() >= n);
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_reset();
        bus.i_pkt_valid = 0; bus.i_pkt = '0; bus.i_phv_valid = 0; bus.i_phv = '0; bus.i_ready = 1;
        i_rst_n = 0;
        repeat (3) @(negedge i_clk);
        n_run++; if (bus.o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_pkt_valid); end
        n_run++; if (bus.o_pkt !== '0) begin n_fail++; $display("FAIL reset_pkt got %h want 0", bus.o_pkt); end
        n_run++; if (bus.o_err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.o_err_ovf); end
        n_run++; if (bus.o_cnt_tx !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_tx got %0d want 0", bus.o_cnt_tx); end
        n_run++; if (bus.o_cnt_drop !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_drop got %0d want 0", bus.o_cnt_drop); end
        i_rst_n = 1;
        repeat (3) @(negedge i_clk);
        n_run++; if (bus.o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", bus.o_pkt_valid); end
    endtask

    task automatic test_basic4();
        bit ok;
        logic [1023:0] p;
        rx_q.delete(); rx_t.delete(); exp_q.delete();
        p = rand_phv();
        send_pkt(4, 0, -1, p);
        tick();
        bus.i_phv_valid = 1'b1;
        bus.i_phv = p;
        model_phv(p);
        tick();
        bus.i_phv_valid = 1'b0;
        @(negedge i_clk);
        n_run++; if (bus.o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0", bus.o_pkt_valid); end
        @(negedge i_clk);
        n_run++; if (bus.o_pkt_valid !== 1'b1) begin n_fail++; $display("FAIL lat_2cyc got %b want 1", bus.o_pkt_valid); end
        expand();
        wait_rx(exp_q.size(), 200, ok);
        n_run++; if (!ok || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic4_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_run++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic4_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_run++; if (bus.o_cnt_tx !== 32'(cnt_exp(exp_tx))) begin n_fail++; $display("FAIL basic4_cnt_tx got %0d want %0d", bus.o_cnt_tx, cnt_exp(exp_tx)); end
    endtask

    task automatic test_long10();
        bit ok;
        rx_q.delete(); rx_t.delete(); exp_q.delete();
        send_pkt(10, 0, 10, rand_phv());
        expand();
        wait_rx(exp_q.size(), 200, ok);
        n_run++; if (!ok || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL long10_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_run++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL long10_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_hold();
        bit ok;
        int c;
        logic [133:0] snap;
        rx_q.delete(); rx_t.delete(); exp_q.delete();
        send_pkt(4, 0, 4, rand_phv());
        expand();
        c = 0;
        while (rx_q.size() < 2 && c < 100) begin @(negedge i_clk); c++; end
        n_run++; if (rx_q.size() < 2) begin n_fail++; $display("FAIL hold_start got %0d beats want 2", rx_q.size()); end
        @(posedge i_clk); #1;
        bus.i_ready = 1'b0;
        snap = bus.o_pkt;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            n_run++; if (bus.o_pkt !== snap || bus.o_pkt_valid !== 1'b1) begin
                n_fail++; $display("FAIL hold_stable cyc%0d got %h/%b want %h/1", i, bus.o_pkt, bus.o_pkt_valid, snap);
            end
        end
        @(posedge i_clk); #1;
        bus.i_ready = 1'b1;
        wait_rx(exp_q.size(), 200, ok);
        n_run++; if (!ok || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL hold_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_run++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hold_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_drop();
        bit ok;
        rx_q.delete(); rx_t.delete(); exp_q.delete();
        send_pkt(85, 0, -1, '0);
        send_pkt(85, 0, -1, '0);
        send_pkt(4, 0, -1, '0);
        send_phv(rand_phv());
        send_phv(rand_phv());
        send_phv(rand_phv());
        expand();
        wait_rx(exp_q.size(), 1000, ok);
        send_pkt(5, 0, 5, rand_phv());
        expand();
        wait_rx(exp_q.size(), 200, ok);
        n_run++; if (!ok || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_run++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL drop_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_run++; if (bus.o_cnt_drop !== 32'(cnt_exp(exp_drop))) begin n_fail++; $display("FAIL drop_cnt got %0d want %0d", bus.o_cnt_drop, cnt_exp(exp_drop)); end
        n_run++; if (bus.o_cnt_tx !== 32'(cnt_exp(exp_tx))) begin n_fail++; $display("FAIL drop_cnt_tx got %0d want %0d", bus.o_cnt_tx, cnt_exp(exp_tx)); end
        n_run++; if (bus.o_err_ovf !== exp_err) begin n_fail++; $display("FAIL drop_err got %b want %b", bus.o_err_ovf, exp_err); end
    endtask

    task automatic test_trickle();
        bit ok;
        int n;
        rx_q.delete(); rx_t.delete(); exp_q.delete();
        send_pkt(6, 2, 1, rand_phv());
        expand();
        wait_rx(exp_q.size(), 200, ok);
        n = rx_q.size();
        n_run++; if (!ok || n != exp_q.size()) begin n_fail++; $display("FAIL trickle_count got %0d want %0d", n, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            n_run++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL trickle_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        if (n > 1) begin
            n_run++; if (rx_t[n-1] - rx_t[0] <= n - 1) begin n_fail++; $display("FAIL trickle_gap span %0d cycles want > %0d", rx_t[n-1] - rx_t[0], n - 1); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int nb;
        rx_q.delete(); rx_t.delete(); exp_q.delete();
        rand_ready = 1;
        for (int i = 0; i < 16; i++) begin
            nb = $urandom_range(2, 12);
            send_pkt(nb, $urandom_range(0, 2), $urandom_range(0, nb), rand_phv());
        end
        expand();
        wait_rx(exp_q.size(), 3000, ok);
        rand_ready = 0;
        @(posedge i_clk); #1;
        bus.i_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        n_run++; if (!ok || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_run++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_run++; if (bus.o_cnt_tx !== 32'(cnt_exp(exp_tx))) begin n_fail++; $display("FAIL random_cnt_tx got %0d want %0d", bus.o_cnt_tx, cnt_exp(exp_tx)); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) send_pkt(2, 0, -1, '0);
        repeat (3) @(negedge i_clk);
        n_run++; if (bus.o_err_ovf !== exp_err) begin n_fail++; $display("FAIL ovf_err got %b want %b", bus.o_err_ovf, exp_err); end
        n_run++; if (bus.o_cnt_drop !== 32'(cnt_exp(exp_drop))) begin n_fail++; $display("FAIL ovf_cnt_drop got %0d want %0d", bus.o_cnt_drop, cnt_exp(exp_drop)); end
        n_run++; if (bus.o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_valid got %b want 0", bus.o_pkt_valid); end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int c;
        @(negedge i_clk); #2;
        i_rst_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        n_run++; if (bus.o_err_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_err_clear got %b want 0", bus.o_err_ovf); end
        send_pkt(10, 0, 10, rand_phv());
        c = 0;
        while (rx_q.size() < 3 && c < 100) begin @(negedge i_clk); c++; end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_run++; if (bus.o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b want 0", bus.o_pkt_valid); end
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        send_pkt(4, 0, 4, rand_phv());
        expand();
        wait_rx(exp_q.size(), 200, ok);
        n_run++; if (!ok || rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_run++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_run++; if (bus.o_cnt_tx !== 32'(cnt_exp(exp_tx))) begin n_fail++; $display("FAIL rst_cnt_tx got %0d want %0d", bus.o_cnt_tx, cnt_exp(exp_tx)); end
    endtask

    initial begin
        test_reset();
        test_basic4();
        test_long10();
        test_hold();
        test_drop();
        test_trickle();
        test_random();
        test_overflow();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
